// File: rtl/trigger_sequencer.sv
// trigger_sequencer: arm/clear/pre/wait/post/done capture controller for a triggered sample buffer.
module trigger_sequencer #(
   parameter int CNT_W        = 16,
   parameter int RST_CYCLES   = 5,
   parameter int AUTO_TIMEOUT = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             arm_req,
   input  logic             abort,
   input  logic [CNT_W-1:0] pre_len,
   input  logic [CNT_W-1:0] post_len,
   input  logic             auto_en,
   input  logic             triggered,
   input  logic             rd_ack,
   output logic             armed,
   output logic             t_reset,
   output logic             wr_en,
   output logic             trig_forced,
   output logic             busy,
   output logic             done,
   output logic [2:0]       state
);
   localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_PRE = 3'd2, S_WAIT = 3'd3, S_POST = 3'd4, S_DONE = 3'd5;
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(AUTO_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [2:0]       st, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, pre_q, post_q, pre_last, post_last;
   logic             timeout, fire, forced_nxt;
   logic             armed_d, t_reset_d, wr_en_d, busy_d, done_d;

   // a zero length still gives one write cycle
   assign pre_last  = (pre_q == '0) ? '0 : pre_q - 1'b1;
   assign post_last = (post_q == '0) ? '0 : post_q - 1'b1;
   assign state     = st;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st          <= S_IDLE;
         cnt         <= '0;
         pre_q       <= '0;
         post_q      <= '0;
         armed       <= 1'b0;
         t_reset     <= 1'b0;
         wr_en       <= 1'b0;
         trig_forced <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         st          <= nxt;
         cnt         <= cnt_nxt;
         if (st == S_IDLE && nxt == S_CLEAR) begin
            pre_q  <= pre_len;
            post_q <= post_len;
         end
         armed       <= armed_d;
         t_reset     <= t_reset_d;
         wr_en       <= wr_en_d;
         trig_forced <= forced_nxt;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

   always_comb begin
      nxt     = st;
      timeout = auto_en && cnt == TO_LAST;
      fire    = 1'b0;
      case (st)
         S_IDLE:  nxt = arm_req ? S_CLEAR : S_IDLE;
         S_CLEAR: nxt = (cnt == RST_LAST) ? S_PRE : S_CLEAR;
         S_PRE:   nxt = (cnt == pre_last) ? S_WAIT : S_PRE;
         S_WAIT: begin
            nxt  = (triggered || timeout) ? S_POST : S_WAIT;
            fire = timeout && !triggered;
         end
         S_POST:  nxt = (cnt == post_last) ? S_DONE : S_POST;
         S_DONE:  nxt = rd_ack ? S_IDLE : S_DONE;
         default: nxt = S_IDLE;
      endcase
      if (abort)
         nxt = S_IDLE;
      // counter restarts on every state change and saturates instead of wrapping
      cnt_nxt    = (nxt != st || (st == S_WAIT && !auto_en)) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      forced_nxt = (nxt == S_IDLE) ? 1'b0 : (fire || trig_forced);
   end

   always_comb begin
      armed_d   = nxt == S_WAIT;
      t_reset_d = nxt == S_CLEAR;
      wr_en_d   = nxt == S_PRE || nxt == S_WAIT || nxt == S_POST;
      busy_d    = nxt != S_IDLE;
      done_d    = nxt == S_DONE;
   end
endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: randomized capture scenarios checked against a phase-length model.
module tb_trigger_sequencer;
   localparam int CNT_W = 8, R = 5, TO = 20, NONE = 1 << 30;

   logic             clk = 1'b0, reset_n = 1'b0, arm_req = 1'b0, abort = 1'b0;
   logic             auto_en = 1'b0, triggered = 1'b0, rd_ack = 1'b0;
   logic [CNT_W-1:0] pre_len = '0, post_len = '0;
   logic             armed, t_reset, wr_en, trig_forced, busy, done;
   logic [2:0]       state;
   logic [8:0]       obs;
   int               vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   trigger_sequencer #(.CNT_W(CNT_W), .RST_CYCLES(R), .AUTO_TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .arm_req(arm_req), .abort(abort),
      .pre_len(pre_len), .post_len(post_len), .auto_en(auto_en), .triggered(triggered),
      .rd_ack(rd_ack), .armed(armed), .t_reset(t_reset), .wr_en(wr_en),
      .trig_forced(trig_forced), .busy(busy), .done(done), .state(state)
   );

   assign obs = {state, armed, t_reset, wr_en, trig_forced, busy, done};

   // phase 0..5 = idle, clear, pre, wait, post, done
   function automatic logic [8:0] ev(int ph, bit f);
      return {3'(ph), ph == 3, ph == 1, ph >= 2 && ph <= 4, f && ph >= 4, ph != 0, ph == 5};
   endfunction

   task automatic check(string tag, int c, logic [8:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s c=%0d got=%h exp=%h", tag, c, obs, exp);
      end
   endtask

   // t: first cycle (after the arm edge) with triggered high; ab: cycle whose edge samples abort
   task automatic capture(string tag, int pre, int post, int t, bit au, int ab);
      int P, Q, k, W, c0, last, ph, wr;
      bit f, gone;
      P    = pre == 0 ? 1 : pre;
      Q    = post == 0 ? 1 : post;
      k    = t < R + P ? 0 : t - (R + P);
      f    = au && k > TO - 1;
      W    = f ? TO : k + 1;
      c0   = R + P + W + Q;
      last = c0 + 2;
      if (ab >= 0 && ab + 2 < last) last = ab + 2;
      wr   = 0;
      @(negedge clk);
      arm_req = 1'b1; pre_len = CNT_W'(pre); post_len = CNT_W'(post);
      auto_en = au; abort = 1'b0; rd_ack = 1'b0; triggered = 1'b0;
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         gone = ab >= 0 && c > ab;
         ph = (gone || c > c0 + 1) ? 0 : c < R ? 1 : c < R + P ? 2 : c < R + P + W ? 3 : c < c0 ? 4 : 5;
         check(tag, c, ev(ph, f));
         wr += int'(wr_en);
         arm_req   = ph != 0 && $urandom_range(0, 3) == 0;
         triggered = c >= t;
         rd_ack    = ph == 5 ? c == c0 + 1 : ph != 0 && $urandom_range(0, 3) == 0;
         abort     = c == ab;
         pre_len   = CNT_W'($urandom);
         post_len  = CNT_W'($urandom);
      end
      arm_req = 1'b0; rd_ack = 1'b0; abort = 1'b0; triggered = 1'b0;
      if (ab < 0) begin
         vectors++;
         assert (wr == P + W + Q) else begin
            miscompares++;
            $error("FAIL %s_wr_count got=%0d exp=%0d", tag, wr, P + W + Q);
         end
      end
   endtask

   initial begin
      int pre, post, t, ab;
      bit au;
      repeat (3) @(negedge clk);
      check("reset", 0, ev(0, 0));
      reset_n = 1'b1;
      @(negedge clk);
      check("after_reset", 0, ev(0, 0));

      capture("basic", 4, 8, R + 4 + 2, 0, -1);
      capture("forced", 3, 5, NONE, 1, -1);
      capture("trig_at_timeout", 3, 5, R + 3 + TO - 1, 1, -1);
      capture("ignored_trig", 6, 4, 0, 1, -1);
      capture("abort_post", 4, 8, R + 5, 0, R + 4 + 2 + 2);
      capture("after_abort", 4, 8, R + 4 + 3, 0, -1);
      capture("zero_len", 0, 0, R + 1 + 3, 0, -1);
      capture("abort_clear", 3, 3, R + 10, 1, 2);
      capture("abort_wait_forced", 2, 3, NONE, 1, R + 2 + TO + 1);
      capture("saturate", 255, 255, R + 255 + 2, 0, -1);

      for (int i = 0; i < 12; i++) begin
         pre  = int'($urandom_range(0, 15));
         post = int'($urandom_range(0, 15));
         au   = 1'($urandom_range(0, 1));
         t    = (au && $urandom_range(0, 2) == 0) ? NONE : int'($urandom_range(0, R + 15 + TO + 5));
         ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 45)) : -1;
         capture("rand", pre, post, t, au, ab);
      end

      // asynchronous reset while waiting for a trigger
      @(negedge clk);
      arm_req = 1'b1; pre_len = 8'd2; post_len = 8'd3; auto_en = 1'b0; triggered = 1'b0;
      @(negedge clk);
      arm_req = 1'b0;
      repeat (8) @(negedge clk);
      check("wait_before_rst", 8, ev(3, 0));
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check("async_rst", 0, ev(0, 0));
      @(negedge clk);
      check("rst_held", 0, ev(0, 0));
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_release", 0, ev(0, 0));
      capture("post_rst", 2, 2, R + 2 + 1, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 Parameter CNT_W, 16, width of the pre/post length inputs and all internal counters.
REQ-002 Parameter RST_CYCLES, 5, length in cycles of the t_reset pulse; legal range 1..255.
REQ-003 Parameter AUTO_TIMEOUT, 50000, cycles in WAIT before a forced trigger; legal range 1..2^CNT_W-1.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 arm_req  input  1  single-cycle pulse that starts a capture.
REQ-007 abort  input  1  cancels any capture in progress.
REQ-008 pre_len  input  CNT_W  pre-trigger samples written before the trigger is accepted.
REQ-009 post_len  input  CNT_W  post-trigger samples written after the trigger.
REQ-010 auto_en  input  1  enables the timeout forced trigger.
REQ-011 triggered  input  1  latched comparator trigger flag from the trigger front end.
REQ-012 rd_ack  input  1  single-cycle pulse: readout of the captured buffer is complete.
REQ-013 armed  output  1  enables trigger detection in the front end.
REQ-014 t_reset  output  1  clears the front-end trigger latch and comparator reset.
REQ-015 wr_en  output  1  sample-buffer write enable, one sample per cycle.
REQ-016 trig_forced  output  1  capture ended on timeout, not on a real trigger.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 done  output  1  capture complete, awaiting readout.
REQ-019 state  output  3  current state code, for debug.

Function
REQ-020 States and codes SHALL be IDLE=0, CLEAR=1, PRE=2, WAIT=3, POST=4, DONE=5; codes 6-7 SHALL return to IDLE on the next cycle.
REQ-021 All outputs SHALL be registered Moore decodes of state; arm_req sampled at edge n SHALL give t_reset=1 after edge n.
REQ-022 IDLE: arm_req=1 SHALL latch pre_len/post_len into internal registers and enter CLEAR; all other outputs SHALL be 0.
REQ-023 CLEAR: t_reset=1 for exactly RST_CYCLES cycles, then enter PRE; armed=0, wr_en=0; triggered SHALL be ignored.
REQ-024 PRE: wr_en=1, armed=0, for exactly max(pre_len_latched,1) cycles, then enter WAIT; triggered SHALL be ignored.
REQ-025 WAIT: armed=1, wr_en=1; triggered=1 SHALL enter POST on the next edge.
REQ-026 WAIT timeout: the counter SHALL clear on WAIT entry; if auto_en=1 and the counter reaches AUTO_TIMEOUT-1 with triggered=0, the block SHALL enter POST and set trig_forced=1.
REQ-027 triggered=1 and timeout in the same cycle SHALL count as a real trigger (trig_forced stays 0).
REQ-028 auto_en=0 SHALL hold the counter at 0, so WAIT is unbounded.
REQ-029 POST: armed=0, wr_en=1 for exactly max(post_len_latched,1) cycles, then enter DONE.
REQ-030 DONE: done=1, wr_en=0, armed=0; rd_ack=1 SHALL enter IDLE and clear done and trig_forced.
REQ-031 abort=1 in any state SHALL enter IDLE on the next edge; it SHALL take priority over every other transition and clear trig_forced.
REQ-032 arm_req outside IDLE and rd_ack outside DONE SHALL be ignored.
REQ-033 Changes to pre_len/post_len after arming SHALL have no effect until the next arm.
REQ-034 Counters SHALL saturate, never wrap: pre_len=post_len=2^CNT_W-1 SHALL give exactly that many writes.
REQ-035 Total wr_en cycles per capture SHALL equal max(pre,1) + WAIT cycles + max(post,1).

Reset
REQ-036 reset_n=0 SHALL immediately force state=IDLE, all counters and latched lengths to 0, and all outputs to 0.
REQ-037 After reset_n deasserts, the first state transition SHALL occur no earlier than the first rising clk edge.
REQ-038 Reset asserted mid-capture SHALL drop armed, wr_en and t_reset within the same cycle, without waiting for a clock edge.

Verification
REQ-039 Basic capture (RST_CYCLES=5, pre=4, post=8): arm -> t_reset 5 cycles; wr_en 4 cycles with armed=0, then armed=1; trigger -> 8 more wr_en cycles; done=1; rd_ack -> IDLE.
REQ-040 Forced trigger (AUTO_TIMEOUT=20, auto_en=1, no trigger) -> armed high 20 cycles, then POST with trig_forced=1; trig_forced stays set through DONE and clears on rd_ack.
REQ-041 Ignored trigger: triggered=1 during CLEAR and PRE -> no POST entry; triggered still high on WAIT entry -> POST on the following edge.
REQ-042 Abort in POST at cycle 3 of 8 -> IDLE next edge, wr_en=0, done never asserts; a new arm_req then gives a full capture.
REQ-043 Zero lengths (pre=0, post=0) -> exactly 1 PRE and 1 POST write cycle; arm_req during POST and rd_ack during WAIT have no effect.
REQ-044 Async reset: pulse reset_n low between clock edges during WAIT -> armed and wr_en drop immediately, state=0.
